// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl -- central pipeline control for the 5-stage MIPS core.
//
// Merges the ID and EX stall requests with a wait-state FSM that tracks
// MEM-stage data-bus accesses. The FSM also aborts an access that runs too
// long. From these it drives the shared stall vector and the flush line.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   stallreq_id  ID stall request (load-use hazard)
//   stallreq_ex  EX stall request (mult/div busy)
//   mem_req      MEM stage holds a load/store this cycle
//   mem_ack      data bus completes the access this cycle
//   flush_req    exception/redirect, kill in-flight instructions
//   stall[5:0]   [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold
//   flush        clear all pipeline registers
//   mem_err      one-cycle pulse while the FSM sits in ERR (access timeout)
//   busy_wait    FSM is in WAIT
//   stall_cnt    saturating count of cycles with stall[0]=1 since reset
//   dbg_state    current FSM state (0=IDLE 1=WAIT 2=ERR)
//
// Handshake: the bus is a plain req/ack pair. mem_req is held by MEM until
// the cycle in which mem_ack is high. That cycle completes the access and
// the instruction advances. No ack within TIMEOUT cycles gives ERR.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             mem_err,
  output logic             busy_wait,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // TIMEOUT is limited to 2..255, so an 8-bit wait counter is enough.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stallreq_mem;
  logic [5:0]       w_stall;

  // The MEM stall drops in the ack cycle so that cycle's instruction moves
  // on. It also drops in the final WAIT cycle before the ERR abort.
  always_comb begin
    w_stallreq_mem = ((r_state == ST_IDLE) && mem_req && !mem_ack) ||
                     ((r_state == ST_WAIT) && !mem_ack && (r_wait_cnt < WAIT_LAST));
  end

  // Priority high to low. Lower requests are absorbed because the
  // upstream stages are already frozen by the winner.
  always_comb begin
    w_stall = 6'b000000;
    if (rst || flush_req || (r_state == ST_ERR)) begin
      w_stall = 6'b000000;
    end else if (w_stallreq_mem) begin
      w_stall = 6'b011111;  // WB still runs, so MEM/WB takes a bubble
    end else if (stallreq_ex) begin
      w_stall = 6'b001111;
    end else if (stallreq_id) begin
      w_stall = 6'b000111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
    end else if (flush_req) begin
      // A redirect kills the access, so it ends without an error.
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req && !mem_ack) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state    <= ST_ERR;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ERR: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 8'd0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Performance counter. It holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign flush     = !rst && (flush_req || (r_state == ST_ERR));
  assign mem_err   = (r_state == ST_ERR);
  assign busy_wait = (r_state == ST_WAIT);
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule
